// File: rtl/fixp_normalizer_pkg.sv
// Shared widths, beat layouts and the clogb2 helper for the fixed-to-float normalizer.
package fixp_normalizer_pkg;

  localparam int DEF_FIXP_WIDTH = 192;
  localparam int DEF_FRAC_WIDTH = 96;
  localparam int DEF_POS_WIDTH  = 8;
  localparam int DEF_MANT_WIDTH = 53;
  localparam int DEF_EXP_WIDTH  = 11;
  localparam int DEF_EXP_BIAS   = 1023;
  localparam int DEF_SHIFT_BITS = 2;

  localparam int IN_DATA_W  = DEF_FIXP_WIDTH + DEF_POS_WIDTH + 1;
  localparam int OUT_DATA_W = DEF_EXP_WIDTH + DEF_MANT_WIDTH + 2;

  // Number of bits needed to represent n.
  function automatic int clogb2(input int n);
    int bits;
    bits = 0;
    for (int v = n; v > 0; v = v >> 1) bits++;
    return bits;
  endfunction

  typedef struct packed {
    logic [DEF_FIXP_WIDTH-1:0] value;
    logic [DEF_POS_WIDTH-1:0]  lzc;
    logic                      find;
  } fixp_in_t;

  typedef struct packed {
    logic [DEF_EXP_WIDTH-1:0]  exp;
    logic [DEF_MANT_WIDTH-1:0] mant;
    logic                      sticky;
    logic                      zero;
  } fixp_out_t;

endpackage

// File: rtl/fixp_normalizer_shift_stage.sv
// One registered slice of the normalizing barrel shifter; consumes SHIFT_BITS of the lzc.
module fixp_normalizer_shift_stage #(
  parameter int WIDTH      = 192,
  parameter int POS_WIDTH  = 8,
  parameter int SHIFT_BITS = 2,
  parameter int STAGE      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 prev_vld,
  input  logic [WIDTH-1:0]     prev_val,
  input  logic [POS_WIDTH-1:0] prev_lzc,
  input  logic                 prev_find,
  output logic                 vld,
  output logic [WIDTH-1:0]     val,
  output logic [POS_WIDTH-1:0] lzc,
  output logic                 find
);

  localparam int LO         = STAGE * SHIFT_BITS;
  localparam int DIGIT_MASK = ((2 ** SHIFT_BITS) - 1) << LO;

  // Masking in place gives the digit already weighted by its stage position.
  logic [31:0] amt;
  assign amt = 32'(prev_lzc) & DIGIT_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld <= 1'b0;
    else if (en) vld <= prev_vld;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      val  <= prev_val << amt;
      lzc  <= prev_lzc;
      find <= prev_find;
    end
  end

endmodule

// File: rtl/fixp_normalizer.sv
// Normalizes a fixed-point value by its leading-zero count into {exp, mant, sticky, zero}.
module fixp_normalizer
  import fixp_normalizer_pkg::*;
#(
  parameter int FIXP_WIDTH = DEF_FIXP_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
  parameter int POS_WIDTH  = DEF_POS_WIDTH,
  parameter int MANT_WIDTH = DEF_MANT_WIDTH,
  parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
  parameter int EXP_BIAS   = DEF_EXP_BIAS,
  parameter int SHIFT_BITS = DEF_SHIFT_BITS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                fixp_in_tvalid,
  output logic                                fixp_in_tready,
  input  logic [FIXP_WIDTH+POS_WIDTH:0]       fixp_in_tdata,
  output logic                                fixp_out_tvalid,
  input  logic                                fixp_out_tready,
  output logic [EXP_WIDTH+MANT_WIDTH+1:0]     fixp_out_tdata
);

  localparam int NSHIFT  = (POS_WIDTH + SHIFT_BITS - 1) / SHIFT_BITS;
  localparam int EW      = EXP_WIDTH + 2;
  localparam int UNB_EXP = FIXP_WIDTH - 1 - FRAC_WIDTH;
  localparam logic signed [EW-1:0] EXP_MIN = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** EXP_WIDTH) - 2);

  if (MANT_WIDTH > FIXP_WIDTH || POS_WIDTH < clogb2(FIXP_WIDTH - 1)) begin : g_param_err
    $error("fixp_normalizer: MANT_WIDTH/POS_WIDTH inconsistent with FIXP_WIDTH");
  end

  // Whole pipeline moves as one; bubbles are kept in place.
  logic advance;
  assign advance        = ~fixp_out_tvalid | fixp_out_tready;
  assign fixp_in_tready = advance;

  logic                  in_vld_q;
  logic [FIXP_WIDTH-1:0] in_val_q;
  logic [POS_WIDTH-1:0]  in_lzc_q;
  logic                  in_find_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_vld_q <= 1'b0;
    else if (advance) in_vld_q <= fixp_in_tvalid;
  end

  always_ff @(posedge clk) begin
    if (advance) {in_val_q, in_lzc_q, in_find_q} <= fixp_in_tdata;
  end

  logic                  vld_p  [NSHIFT+1];
  logic [FIXP_WIDTH-1:0] val_p  [NSHIFT+1];
  logic [POS_WIDTH-1:0]  lzc_p  [NSHIFT+1];
  logic                  find_p [NSHIFT+1];

  assign vld_p[0]  = in_vld_q;
  assign val_p[0]  = in_val_q;
  assign lzc_p[0]  = in_lzc_q;
  assign find_p[0] = in_find_q;

  for (genvar k = 0; k < NSHIFT; k++) begin : g_shift
    fixp_normalizer_shift_stage #(
      .WIDTH      (FIXP_WIDTH),
      .POS_WIDTH  (POS_WIDTH),
      .SHIFT_BITS (SHIFT_BITS),
      .STAGE      (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (advance),
      .prev_vld  (vld_p[k]),
      .prev_val  (val_p[k]),
      .prev_lzc  (lzc_p[k]),
      .prev_find (find_p[k]),
      .vld       (vld_p[k+1]),
      .val       (val_p[k+1]),
      .lzc       (lzc_p[k+1]),
      .find      (find_p[k+1])
    );
  end

  logic [FIXP_WIDTH-1:0] norm_val;
  logic [POS_WIDTH-1:0]  norm_lzc;
  logic                  norm_find;
  logic                  sticky_raw;

  assign norm_val  = val_p[NSHIFT];
  assign norm_lzc  = lzc_p[NSHIFT];
  assign norm_find = find_p[NSHIFT];

  if (MANT_WIDTH < FIXP_WIDTH) begin : g_sticky
    assign sticky_raw = |norm_val[FIXP_WIDTH-MANT_WIDTH-1:0];
  end else begin : g_no_sticky
    assign sticky_raw = 1'b0;
  end

  logic signed [EW-1:0]  exp_s;
  logic [EXP_WIDTH-1:0]  exp_o;
  logic [MANT_WIDTH-1:0] mant_o;
  logic                  sticky_o;
  logic                  zero_o;

  always_comb begin
    exp_s    = signed'(EW'(UNB_EXP + EXP_BIAS)) - signed'(EW'(norm_lzc));
    exp_o    = exp_s[EXP_WIDTH-1:0];
    mant_o   = norm_val[FIXP_WIDTH-1 -: MANT_WIDTH];
    sticky_o = sticky_raw;
    zero_o   = 1'b0;
    // No leading one found (or lzc past the value) flushes to signed zero.
    if (!norm_find || (32'(norm_lzc) >= FIXP_WIDTH) || (exp_s < EXP_MIN)) begin
      exp_o    = '0;
      mant_o   = '0;
      sticky_o = 1'b0;
      zero_o   = 1'b1;
    end else if (exp_s > EXP_MAX) begin
      exp_o  = '1;
      mant_o = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fixp_out_tvalid <= 1'b0;
    else if (advance) fixp_out_tvalid <= vld_p[NSHIFT];
  end

  always_ff @(posedge clk) begin
    if (advance) fixp_out_tdata <= {exp_o, mant_o, sticky_o, zero_o};
  end

endmodule

// File: tb/tb_fixp_normalizer.sv
// Randomized and directed bench for fixp_normalizer against a single-shift reference model.
module tb_fixp_normalizer;
  import fixp_normalizer_pkg::*;

  localparam int FW    = DEF_FIXP_WIDTH;
  localparam int MW    = DEF_MANT_WIDTH;
  localparam int EXPW  = DEF_EXP_WIDTH;
  localparam int IN_W  = IN_DATA_W;
  localparam int OUT_W = OUT_DATA_W;

  logic clk = 1'b0;
  logic rst;
  logic in_vld, in_rdy, out_vld, out_rdy;
  logic [IN_W-1:0]  in_dat;
  logic [OUT_W-1:0] out_dat;

  always #5 clk = ~clk;

  fixp_normalizer dut (
    .clk             (clk),
    .rst             (rst),
    .fixp_in_tvalid  (in_vld),
    .fixp_in_tready  (in_rdy),
    .fixp_in_tdata   (in_dat),
    .fixp_out_tvalid (out_vld),
    .fixp_out_tready (out_rdy),
    .fixp_out_tdata  (out_dat)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic stall_prev = 1'b0;
  logic [OUT_W-1:0] hold;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference: one shift by the full lzc, then plain integer exponent arithmetic.
  function automatic logic [OUT_W-1:0] ref_model(input logic [IN_W-1:0] d);
    fixp_in_t b;
    fixp_out_t o;
    logic [FW-1:0] sh;
    int e;
    b = d;
    o = '0;
    if (!b.find || int'(b.lzc) >= FW) begin
      o.zero = 1'b1;
      return o;
    end
    e = (FW - 1 - DEF_FRAC_WIDTH) - int'(b.lzc) + DEF_EXP_BIAS;
    if (e < 1) begin
      o.zero = 1'b1;
      return o;
    end
    sh = b.value << b.lzc;
    o.mant = sh[FW-1 -: MW];
    o.sticky = |sh[FW-MW-1:0];
    if (e > (2 ** EXPW) - 2) begin
      o.exp = '1;
      o.mant = '0;
    end else begin
      o.exp = e[EXPW-1:0];
    end
    return o;
  endfunction

  function automatic logic [IN_W-1:0] mk_beat(input logic [FW-1:0] v, input logic [7:0] lzc, input logic find);
    return {v, lzc, find};
  endfunction

  function automatic logic [FW-1:0] rand_wide();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [IN_W-1:0] rand_beat();
    logic [FW-1:0] one;
    logic [FW-1:0] v;
    int lzc;
    logic find;
    one  = 1;
    lzc  = $urandom_range(0, FW - 1);
    find = ($urandom_range(0, 9) != 0);
    v    = rand_wide();
    if (find) v = (v >> (lzc + 1)) | (one << (FW - 1 - lzc));
    return mk_beat(v, 8'(lzc), find);
  endfunction

  // One clock: drive at posedge+1, observe handshakes at posedge+2.
  task automatic tick(input logic ivld, input logic [IN_W-1:0] idat, input logic ordy,
                      output logic fired_in, output logic fired_out, output logic [OUT_W-1:0] got);
    in_vld = ivld;
    in_dat = idat;
    out_rdy = ordy;
    #1;
    if (stall_prev) begin
      chk("stall_tvalid", out_vld, 1'b1);
      chk("stall_tdata", out_dat, hold);
    end
    fired_out = out_vld & out_rdy;
    got = out_dat;
    if (fired_out) begin
      n_out++;
      chk("out_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) chk("out_data", got, exp_q.pop_front());
    end
    stall_prev = out_vld & ~out_rdy;
    hold = out_dat;
    fired_in = in_vld & in_rdy;
    if (fired_in) begin
      n_in++;
      exp_q.push_back(ref_model(idat));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_one(input logic [IN_W-1:0] d, output logic [OUT_W-1:0] got, output int lat);
    logic fi, fo;
    logic [OUT_W-1:0] g;
    int c0, c;
    bit done;
    c0 = -1;
    lat = -1;
    got = '0;
    done = 0;
    for (int i = 0; i < 20 && c0 < 0; i++) begin
      c = cyc;
      tick(1'b1, d, 1'b1, fi, fo, g);
      if (fi) c0 = c;
    end
    for (int i = 0; i < 30 && !done; i++) begin
      c = cyc;
      tick(1'b0, '0, 1'b1, fi, fo, g);
      if (fo) begin
        done = 1;
        got = g;
        lat = c - c0;
      end
    end
    chk("send_no_timeout", done, 1'b1);
  endtask

  initial begin
    fixp_out_t o;
    logic [FW-1:0] one;
    logic [MW-1:0] mant_one;
    logic [OUT_W-1:0] got;
    logic fi, fo;
    int lat, sent;
    logic [IN_W-1:0] cur;

    one = 1;
    mant_one = 1;
    mant_one = mant_one << (MW - 1);
    rst = 1'b1;
    in_vld = 1'b0;
    in_dat = '0;
    out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", out_vld, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_tvalid", out_vld, 1'b0);

    // Leading one already at the MSB.
    send_one(mk_beat(one << (FW - 1), 8'd0, 1'b1), got, lat);
    o = got;
    chk("msb_latency", lat, 6);
    chk("msb_exp", o.exp, 1118);
    chk("msb_mant", o.mant, mant_one);
    chk("msb_sticky", o.sticky, 1'b0);
    chk("msb_zero", o.zero, 1'b0);

    // 1.0
    send_one(mk_beat(one << 96, 8'd95, 1'b1), got, lat);
    o = got;
    chk("one_exp", o.exp, 1023);
    chk("one_mant", o.mant, mant_one);
    chk("one_sticky", o.sticky, 1'b0);

    // 1.0 plus the lowest fraction bit: lost bit shows up as sticky.
    send_one(mk_beat((one << 96) | one, 8'd95, 1'b1), got, lat);
    o = got;
    chk("sticky_exp", o.exp, 1023);
    chk("sticky_mant", o.mant, mant_one);
    chk("sticky_sticky", o.sticky, 1'b1);

    send_one(mk_beat(rand_wide(), 8'(($urandom_range(0, 191))), 1'b0), got, lat);
    o = got;
    chk("nofind_zero", o.zero, 1'b1);
    chk("nofind_exp", o.exp, 0);
    chk("nofind_mant", o.mant, 0);
    chk("nofind_sticky", o.sticky, 1'b0);

    send_one(mk_beat(rand_wide(), 8'd200, 1'b1), got, lat);
    o = got;
    chk("lzc200_zero", o.zero, 1'b1);
    chk("lzc200_exp", o.exp, 0);
    chk("lzc200_mant", o.mant, 0);
    chk("beats_so_far", n_out, 5);

    // Back-to-back random beats with random tready.
    sent = 0;
    cur = rand_beat();
    for (int c = 0; c < 3000 && sent < 100; c++) begin
      tick(1'b1, cur, 1'($urandom_range(0, 1)), fi, fo, got);
      if (fi) begin
        sent++;
        cur = rand_beat();
      end
    end
    chk("rand_sent", sent, 100);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick(1'b0, '0, 1'b1, fi, fo, got);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_in_out_count", n_out, n_in);

    // Reset with four beats in flight, the oldest stalled at the output.
    for (int i = 0; i < 4; i++) tick(1'b1, rand_beat(), 1'b0, fi, fo, got);
    for (int i = 0; i < 20; i++) begin
      if (out_vld) break;
      tick(1'b0, '0, 1'b0, fi, fo, got);
    end
    chk("flight_tvalid", out_vld, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_drop_tvalid", out_vld, 1'b0);
    exp_q.delete();
    stall_prev = 1'b0;
    n_in = 0;
    n_out = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b1, fi, fo, got);
    chk("post_rst_idle_tvalid", out_vld, 1'b0);
    chk("post_rst_no_beats", n_out, 0);
    send_one(rand_beat(), got, lat);
    chk("post_rst_latency", lat, 6);
    chk("post_rst_one_beat", n_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
